// File: rtl/ahb_slave_arbiter_rr.sv
// Per-slave AHB round-robin arbiter with per-beat burst tracking and zero-bubble handover.
// Optional master lock support is enabled by defining AHB_ARB_LOCK_EN.
module ahb_slave_arbiter_rr #(
  parameter int unsigned MASTER_NUM     = 4,
  parameter int unsigned MAX_INCR_BEATS = 16,
  localparam int unsigned IDX_W         = $clog2(MASTER_NUM)
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [MASTER_NUM-1:0]   hreq,
  input  logic [3*MASTER_NUM-1:0] hburst,
  input  logic                    hwait,
`ifdef AHB_ARB_LOCK_EN
  input  logic [MASTER_NUM-1:0]   hmastlock,
`endif
  output logic [MASTER_NUM-1:0]   hgrant,
  output logic                    hsel,
  output logic [IDX_W-1:0]        hmaster,
  output logic                    hlast
);

  localparam int unsigned CNT_W = ($clog2(MAX_INCR_BEATS) > 4) ? $clog2(MAX_INCR_BEATS) : 4;

  localparam logic [2:0] BurstSingle = 3'd0;
  localparam logic [2:0] BurstIncr   = 3'd1;
  localparam logic [2:0] BurstWrap4  = 3'd2;
  localparam logic [2:0] BurstIncr4  = 3'd3;
  localparam logic [2:0] BurstWrap8  = 3'd4;
  localparam logic [2:0] BurstIncr8  = 3'd5;
  localparam logic [2:0] BurstWrap16 = 3'd6;
  localparam logic [2:0] BurstIncr16 = 3'd7;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                state;
  logic [MASTER_NUM-1:0] grant;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      ptr;
  logic [CNT_W-1:0]      count;
  logic [2:0]            burst;

  logic [2:0]            burst_arr [MASTER_NUM];
  logic                  beat_done;
  logic                  release_now;
  logic                  hold;
  logic [IDX_W-1:0]      next_owner;
  logic [IDX_W-1:0]      base;
  logic                  found_hi;
  logic                  found_lo;
  logic [IDX_W-1:0]      hi_idx;
  logic [IDX_W-1:0]      lo_idx;
  logic                  win_valid;
  logic [IDX_W-1:0]      win_idx;

  always_comb begin
    for (int i = 0; i < int'(MASTER_NUM); i++) begin
      burst_arr[i] = hburst[3*i +: 3];
    end
  end

  assign hsel      = |grant;
  assign hgrant    = grant & ~{MASTER_NUM{hwait}};
  assign hmaster   = owner;
  assign beat_done = hsel & ~hwait;

  always_comb begin
    hlast = 1'b0;
    if (state == StBusy) begin
      unique case (burst)
        BurstSingle:             hlast = (count == '0);
        BurstIncr:               hlast = ~hreq[owner] |
                                         (count == CNT_W'(MAX_INCR_BEATS - 1));
        BurstWrap4, BurstIncr4:   hlast = (count == CNT_W'(3));
        BurstWrap8, BurstIncr8:   hlast = (count == CNT_W'(7));
        BurstWrap16, BurstIncr16: hlast = (count == CNT_W'(15));
        default:                 hlast = 1'b0;
      endcase
    end
  end

  assign release_now = beat_done & hlast;

`ifdef AHB_ARB_LOCK_EN
  assign hold = release_now & hmastlock[owner];
`else
  assign hold = 1'b0;
`endif

  assign next_owner = (owner == IDX_W'(MASTER_NUM - 1)) ? '0 : owner + 1'b1;

  // On release the search already starts from the advanced pointer so handover has no bubble.
  assign base = release_now ? next_owner : ptr;

  // Round-robin: first requester at or above base, otherwise first requester below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(MASTER_NUM); i++) begin
      if (hreq[i] && !found_hi && (i >= int'(base))) begin
        found_hi = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (hreq[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    win_valid = found_hi | found_lo;
    win_idx   = found_hi ? hi_idx : lo_idx;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= StIdle;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
      count <= '0;
      burst <= BurstSingle;
    end else begin
      unique case (state)
        StIdle: begin
          if (win_valid) begin
            state <= StBusy;
            grant <= MASTER_NUM'(1) << win_idx;
            owner <= win_idx;
            burst <= burst_arr[win_idx];
            count <= '0;
          end
        end
        StBusy: begin
          if (beat_done) begin
            if (!hlast) begin
              count <= count + CNT_W'(1);
            end else if (hold) begin
              // Locked owner starts a fresh burst without giving up the slave.
              count <= '0;
              burst <= burst_arr[owner];
            end else begin
              ptr <= next_owner;
              if (win_valid) begin
                grant <= MASTER_NUM'(1) << win_idx;
                owner <= win_idx;
                burst <= burst_arr[win_idx];
                count <= '0;
              end else begin
                state <= StIdle;
                grant <= '0;
                owner <= '0;
                count <= '0;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter_rr.sv
// Scoreboard bench for ahb_slave_arbiter_rr: directed scenarios followed by random traffic,
// checked against a transaction-level arbitration model. Define AHB_ARB_LOCK_EN to cover locking.
module tb_ahb_slave_arbiter_rr;

  localparam int N    = 4;
  localparam int MAXB = 16;

  logic           hclk = 1'b0;
  logic           hreset = 1'b1;
  logic [N-1:0]   hreq = '0;
  logic [N-1:0]   hmastlock = '0;
  logic [3*N-1:0] hburst = '0;
  logic           hwait = 1'b0;
  logic [N-1:0]   hgrant;
  logic           hsel;
  logic [1:0]     hmaster;
  logic           hlast;

  ahb_slave_arbiter_rr #(
    .MASTER_NUM    (N),
    .MAX_INCR_BEATS(MAXB)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .hreq     (hreq),
    .hburst   (hburst),
    .hwait    (hwait),
`ifdef AHB_ARB_LOCK_EN
    .hmastlock(hmastlock),
`endif
    .hgrant   (hgrant),
    .hsel     (hsel),
    .hmaster  (hmaster),
    .hlast    (hlast)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         s;
    logic [1:0]   m;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: who owns the slave, how many beats of its burst are done, where RR starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_len   = 1;
  bit m_incr  = 1'b0;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return MAXB;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic bit model_last();
    if (m_owner < 0) return 1'b0;
    if (m_incr) return (hreq[m_owner] == 1'b0) || (m_beats + 1 == MAXB);
    return (m_beats + 1 == m_len);
  endfunction

  function automatic int pick(input int start);
    for (int k = 0; k < N; k++) begin
      if (hreq[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic take(input int who);
    logic [2:0] b;
    b       = hburst[3*who +: 3];
    m_owner = who;
    m_beats = 0;
    m_len   = burst_len(b);
    m_incr  = (b == 3'd1);
  endtask

  // Advance the model across one rising edge using the inputs present before the edge.
  task automatic model_step();
    int w;
    bit locked;
    if (hreset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_len   = 1;
      m_incr  = 1'b0;
    end else if (m_owner < 0) begin
      w = pick(m_ptr);
      if (w >= 0) take(w);
    end else if (!hwait) begin
      if (model_last()) begin
        locked = 1'b0;
`ifdef AHB_ARB_LOCK_EN
        locked = hmastlock[m_owner];
`endif
        if (locked) begin
          take(m_owner);
        end else begin
          m_ptr = (m_owner + 1) % N;
          w = pick(m_ptr);
          if (w >= 0) take(w);
          else m_owner = -1;
        end
      end else begin
        m_beats++;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.s = (m_owner >= 0);
    e.m = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.g = (m_owner >= 0 && !hwait) ? N'(1) << m_owner : '0;
    e.l = model_last();
    sb.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] req, input logic [3*N-1:0] bst, input logic w,
                      input logic rst, input logic [N-1:0] lk);
    @(posedge hclk);
    #1;
    model_step();
    hreset    = rst;
    hreq      = req;
    hburst    = bst;
    hwait     = w;
    hmastlock = lk;
    push_expect();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest queued expectation.
  exp_t cur;
  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("hgrant", 32'(hgrant), 32'(cur.g));
      chk("hsel", 32'(hsel), 32'(cur.s));
      chk("hmaster", 32'(hmaster), 32'(cur.m));
      chk("hlast", 32'(hlast), 32'(cur.l));
    end
  end

  function automatic logic [3*N-1:0] all_b(input logic [2:0] b);
    return {N{b}};
  endfunction

  logic [N-1:0]   want;
  logic [3*N-1:0] rb;
  logic [N-1:0]   rl;

  initial begin
    // Reset held with all masters requesting.
    for (int i = 0; i < 2; i++) step(4'b1111, all_b(3'd0), 1'b0, 1'b1, '0);
    // Back-to-back SINGLE rotation.
    for (int i = 0; i < 6; i++) step(4'b1111, all_b(3'd0), 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) step(4'b0000, all_b(3'd0), 1'b0, 1'b0, '0);
    // Master 2 INCR4 stretched by wait states while master 3 queues behind it.
    step(4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, 1'b0, 1'b0, '0);
    for (int k = 0; k < 10; k++)
      step(4'b1100, {3'd0, 3'd3, 3'd0, 3'd0}, (k >= 1 && k <= 3), 1'b0, '0);
    for (int i = 0; i < 3; i++) step(4'b0000, all_b(3'd0), 1'b0, 1'b0, '0);
    // Master 1 undefined-length INCR held long enough to hit the forced release.
    step(4'b0010, {3'd0, 3'd0, 3'd1, 3'd0}, 1'b0, 1'b0, '0);
    for (int i = 0; i < 40; i++) step(4'b1111, {3'd0, 3'd0, 3'd1, 3'd0}, 1'b0, 1'b0, '0);
    // Reset in the middle of an INCR8, then fresh contention.
    for (int i = 0; i < 3; i++) step(4'b0000, all_b(3'd0), 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(4'b0001, all_b(3'd5), 1'b0, 1'b0, '0);
    step(4'b1111, all_b(3'd5), 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(4'b1111, all_b(3'd0), 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(4'b0000, all_b(3'd0), 1'b0, 1'b1, '0);
    // Master 0 locked across SINGLE transfers with master 1 waiting.
    for (int i = 0; i < 4; i++) step(4'b0011, all_b(3'd0), 1'b0, 1'b0, 4'b0001);
    for (int i = 0; i < 4; i++) step(4'b0011, all_b(3'd0), 1'b0, 1'b0, 4'b0000);
    // Random traffic.
    want = '1;
    rb   = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) want[i] = ~want[i];
        if ($urandom_range(0, 7) == 0) rb[3*i +: 3] = 3'($urandom_range(0, 7));
        rl[i] = ($urandom_range(0, 5) == 0);
      end
`ifndef AHB_ARB_LOCK_EN
      rl = '0;
`endif
      step(want, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0), rl);
    end
    step(4'b0000, all_b(3'd0), 1'b0, 1'b0, '0);
    @(negedge hclk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
